// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with a sequential clear engine, registered read data,
// a read-valid strobe and a busy flag that stalls accesses while the array is swept.
module ram_sp_clr #(
    parameter int unsigned DW           = 4,
    parameter int unsigned AW           = 4,
    parameter bit          CLEAR_ON_RST = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          csn_i,
    input  logic          rwn_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_in_i,
    input  logic          clr_req_i,
    output logic [DW-1:0] data_out_o,
    output logic          rd_valid_o,
    output logic          busy_o
);

    localparam int unsigned DEPTH    = 2 ** AW;
    localparam logic [AW-1:0] LastAddr = {AW{1'b1}};

    typedef enum logic {
        StIdle,
        StClear
    } state_e;

    localparam state_e StReset = CLEAR_ON_RST ? StClear : StIdle;

    state_e        state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          rd_valid_q, rd_valid_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_q [DEPTH];

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        data_out_d = '0;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = addr_i;
        mem_wdata  = data_in_i;

        unique case (state_q)
            StIdle: begin
                // A clear request wins over any access presented on the same edge.
                if (clr_req_i) begin
                    state_d   = StClear;
                    clr_ptr_d = '0;
                end else if (!csn_i && !rwn_i) begin
                    mem_we = 1'b1;
                end else if (!csn_i) begin
                    data_out_d = mem_q[addr_i];
                    rd_valid_d = 1'b1;
                end
            end
            StClear: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                if (clr_ptr_q == LastAddr) begin
                    state_d   = StIdle;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StReset;
            clr_ptr_q  <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is deliberately outside the reset domain; the clear engine zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign data_out_o = data_out_q;
    assign rd_valid_o = rd_valid_q;
    assign busy_o     = (state_q == StClear);

    a_no_valid_while_busy : assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_valid_o && busy_o));

endmodule

// File: tb/tb_ram_sp_clr.sv
// Bench for ram_sp_clr: a 16x4 instance that clears on reset and a 64x8 instance that
// does not, checked every cycle against an access-level model plus literal expectations.
module tb_ram_sp_clr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       csn0, rwn0, clr0;
    logic [3:0] addr0, din0, dout0;
    logic       valid0, busy0;
    logic       csn1, rwn1, clr1;
    logic [5:0] addr1;
    logic [7:0] din1, dout1;
    logic       valid1, busy1;

    ram_sp_clr #(.DW(4), .AW(4), .CLEAR_ON_RST(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .csn_i(csn0), .rwn_i(rwn0), .addr_i(addr0),
        .data_in_i(din0), .clr_req_i(clr0), .data_out_o(dout0), .rd_valid_o(valid0),
        .busy_o(busy0)
    );

    ram_sp_clr #(.DW(8), .AW(6), .CLEAR_ON_RST(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .csn_i(csn1), .rwn_i(rwn1), .addr_i(addr1),
        .data_in_i(din1), .clr_req_i(clr1), .data_out_o(dout1), .rd_valid_o(valid1),
        .busy_o(busy1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Access-level model: a clear is a countdown of DEPTH busy cycles with the array zeroed.
    logic [7:0] mm0 [16];
    logic [7:0] mm1 [64];
    int         mb0, mb1;
    logic [7:0] md0, md1;
    logic       mv0, mv1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mb0 = 16;
            mb1 = 0;
            md0 = 8'h0;
            md1 = 8'h0;
            mv0 = 1'b0;
            mv1 = 1'b0;
            foreach (mm0[i]) mm0[i] = 8'h0;
        end else begin
            md0 = 8'h0;
            mv0 = 1'b0;
            if (mb0 > 0) mb0--;
            else if (clr0) begin
                mb0 = 16;
                foreach (mm0[i]) mm0[i] = 8'h0;
            end else if (!csn0 && !rwn0) mm0[addr0] = {4'h0, din0};
            else if (!csn0) begin
                md0 = mm0[addr0];
                mv0 = 1'b1;
            end

            md1 = 8'h0;
            mv1 = 1'b0;
            if (mb1 > 0) mb1--;
            else if (clr1) begin
                mb1 = 64;
                foreach (mm1[i]) mm1[i] = 8'h0;
            end else if (!csn1 && !rwn1) mm1[addr1] = din1;
            else if (!csn1) begin
                md1 = mm1[addr1];
                mv1 = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("cyc dout0", dout0, md0[3:0]);
            chk("cyc valid0", valid0, mv0);
            chk("cyc busy0", busy0, mb0 > 0);
            chk("cyc dout1", dout1, md1);
            chk("cyc valid1", valid1, mv1);
            chk("cyc busy1", busy1, mb1 > 0);
        end
    end

    task automatic drv0(input logic c, input logic r, input logic [3:0] a,
                        input logic [3:0] d, input logic q);
        csn0 = c; rwn0 = r; addr0 = a; din0 = d; clr0 = q;
    endtask

    task automatic drv1(input logic c, input logic r, input logic [5:0] a,
                        input logic [7:0] d, input logic q);
        csn1 = c; rwn1 = r; addr1 = a; din1 = d; clr1 = q;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200us");
        $fatal(1);
    end

    initial begin
        drv0(1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
        drv1(1'b1, 1'b1, 6'h0, 8'h0, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        chk("post-reset busy0", busy0, 1'b1);
        chk("post-reset busy1", busy1, 1'b0);
        chk("post-reset dout0", dout0, 4'h0);
        chk("post-reset valid0", valid0, 1'b0);
        chk("post-reset valid1", valid1, 1'b0);

        repeat (15) tick();
        chk("busy0 after 15 edges", busy0, 1'b1);
        tick();
        chk("busy0 after 16 edges", busy0, 1'b0);

        for (int a = 0; a < 16; a++) begin
            drv0(1'b0, 1'b1, 4'(a), 4'h0, 1'b0);
            tick();
            chk("cleared word", dout0, 4'h0);
            chk("cleared word valid", valid0, 1'b1);
        end

        drv0(1'b0, 1'b0, 4'd3, 4'hA, 1'b0);
        tick();
        chk("write3 dout", dout0, 4'h0);
        chk("write3 valid", valid0, 1'b0);
        drv0(1'b0, 1'b0, 4'd15, 4'h5, 1'b0);
        tick();
        chk("write15 valid", valid0, 1'b0);
        drv0(1'b0, 1'b1, 4'd3, 4'h0, 1'b0);
        tick();
        chk("read3 dout", dout0, 4'hA);
        chk("read3 valid", valid0, 1'b1);
        drv0(1'b0, 1'b1, 4'd15, 4'h0, 1'b0);
        tick();
        chk("read15 dout", dout0, 4'h5);
        chk("read15 valid", valid0, 1'b1);
        drv0(1'b1, 1'b1, 4'd0, 4'h0, 1'b0);
        tick();
        chk("deselect dout", dout0, 4'h0);
        chk("deselect valid", valid0, 1'b0);

        drv0(1'b0, 1'b0, 4'd7, 4'h6, 1'b0);
        tick();
        drv0(1'b0, 1'b1, 4'd7, 4'h0, 1'b0);
        tick();
        chk("write-then-read", dout0, 4'h6);

        drv0(1'b0, 1'b0, 4'd2, 4'hF, 1'b1);
        tick();
        chk("clr busy0", busy0, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            drv0(1'b0, 1'b1, 4'd2, 4'h0, 1'b0);
            tick();
            chk("read during clear valid", valid0, 1'b0);
            chk("clear busy window", busy0, i < 16);
        end
        drv0(1'b0, 1'b1, 4'd2, 4'h0, 1'b0);
        tick();
        chk("dropped write addr2", dout0, 4'h0);
        chk("dropped write valid", valid0, 1'b1);
        drv0(1'b0, 1'b1, 4'd3, 4'h0, 1'b0);
        tick();
        chk("addr3 cleared", dout0, 4'h0);

        drv1(1'b0, 1'b0, 6'd63, 8'hC3, 1'b0);
        tick();
        drv1(1'b0, 1'b1, 6'd63, 8'h0, 1'b0);
        tick();
        chk("dut1 read63", dout1, 8'hC3);
        chk("dut1 read63 valid", valid1, 1'b1);

        // Start a sweep and reset once clr_ptr has reached 7.
        drv0(1'b1, 1'b1, 4'd0, 4'h0, 1'b1);
        tick();
        drv0(1'b1, 1'b1, 4'd0, 4'h0, 1'b0);
        repeat (7) tick();
        chk("dut1 held before reset", dout1, 8'hC3);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset dout1", dout1, 8'h0);
        chk("async reset valid1", valid1, 1'b0);
        chk("async reset busy1", busy1, 1'b0);
        chk("async reset busy0", busy0, 1'b1);
        chk("async reset dout0", dout0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drv1(1'b1, 1'b1, 6'd0, 8'h0, 1'b0);
        repeat (15) tick();
        chk("restart busy0 after 15", busy0, 1'b1);
        tick();
        chk("restart busy0 after 16", busy0, 1'b0);

        drv1(1'b0, 1'b1, 6'd63, 8'h0, 1'b0);
        tick();
        chk("dut1 array survives reset", dout1, 8'hC3);
        drv1(1'b1, 1'b1, 6'd0, 8'h0, 1'b1);
        tick();
        chk("dut1 clr busy", busy1, 1'b1);
        for (int i = 1; i <= 64; i++) begin
            drv1(1'b0, 1'b1, 6'd63, 8'h0, 1'b0);
            tick();
            chk("dut1 clear busy window", busy1, i < 64);
        end
        drv1(1'b0, 1'b1, 6'd63, 8'h0, 1'b0);
        tick();
        chk("dut1 read63 after clear", dout1, 8'h00);
        chk("dut1 read63 after clear valid", valid1, 1'b1);
        drv1(1'b1, 1'b1, 6'd0, 8'h0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
